wd279x_type1_multi: RTL and testbench

- Type I command executor (RESTORE, SEEK, STEP, STEP-IN, STEP-OUT) for the WD279x FDC, generalised to DRIVES drives.
- Keeps a physical head-cylinder counter per drive and honours the update (u) flag.
- Enforces the 255-step RESTORE limit, and the verify phase checks ID CRC status.
- Sits beside the Type II/III executors and drives the step/direction/head-load lines towards the drive model.

---
 rtl/wd279x_type1_multi.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_wd279x_type1_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wd279x_type1_multi.sv
// wd279x_type1_multi -- Type I command executor (RESTORE, SEEK, STEP,
// STEP-IN, STEP-OUT) for a WD279x-style FDC. It keeps one physical
// head-cylinder counter per drive.
//
// Ports:
//   clk, MRn (sync active-low reset), msclk (1 ms enable), interrupt (abort)
//   command_start/command/reg_data/drive_sel  : command issue
//   reg_track_in/reg_track_out/reg_track_write : track register interface
//   id_valid/id_track/id_crc_ok                : ID field results for verify
//   INDEXn, TRK00n                             : drive sensors (active low)
//   STEPn, SDIRn, HLD                          : drive control lines
//   head_cyl                                   : cylinder of the latched drive
//   status = {0,0,HLD,SEEK_ERR,CRC_ERR,~TRK00n,~INDEXn,busy}
//   INTRQ                                      : one-cycle completion pulse
//
// Optional feature: define WD279X_HEAD_UNLOAD_EN to drop HLD after 15 idle
// index revolutions.
module wd279x_type1_multi #(
  parameter int DRIVES      = 2,
  parameter int MAX_CYL     = 81,
  parameter int INDEX_LIMIT = 5,
  parameter int SETTLE_MS   = 15,
  parameter int TEST        = 0,
  localparam int DSW        = (DRIVES > 1) ? $clog2(DRIVES) : 1
) (
  input  logic           clk,
  input  logic           MRn,
  input  logic           msclk,
  input  logic           interrupt,
  input  logic           command_start,
  input  logic [7:0]     command,
  input  logic [7:0]     reg_data,
  input  logic [DSW-1:0] drive_sel,
  input  logic [7:0]     reg_track_in,
  output logic [7:0]     reg_track_out,
  output logic           reg_track_write,
  input  logic           id_valid,
  input  logic [7:0]     id_track,
  input  logic           id_crc_ok,
  input  logic           INDEXn,
  input  logic           TRK00n,
  output logic           STEPn,
  output logic           SDIRn,
  output logic           HLD,
  output logic [7:0]     head_cyl,
  output logic [7:0]     status,
  output logic           INTRQ
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_COMPARE = 4'd1;
  localparam logic [3:0] S_PULSE   = 4'd2;
  localparam logic [3:0] S_WAIT    = 4'd3;
  localparam logic [3:0] S_VERIFY  = 4'd4;
  localparam logic [3:0] S_SETTLE  = 4'd5;
  localparam logic [3:0] S_SCAN    = 4'd6;
  localparam logic [3:0] S_DONE    = 4'd7;

  localparam logic [7:0] MAX_C     = 8'(MAX_CYL);
  localparam logic [7:0] SETTLE_LD = (TEST != 0) ? 8'd2 : 8'(SETTLE_MS);
  localparam logic [7:0] IDX_LIM   = 8'(INDEX_LIMIT);

  logic [3:0]     state_q, state_d;
  logic [6:0]     cmd_q, cmd_d;
  logic [DSW-1:0] drv_q, drv_d;
  logic [7:0]     target_q, target_d;
  logic [7:0]     step_cnt_q, step_cnt_d;
  logic [7:0]     wait_q, wait_d;
  logic [7:0]     idx_cnt_q, idx_cnt_d;
  logic           stepn_q, stepn_d;
  logic           sdirn_q, sdirn_d;
  logic           hld_q, hld_d;
  logic           seek_err_q, seek_err_d;
  logic           crc_err_q, crc_err_d;
  logic [7:0]     trk_out_q, trk_out_d;
  logic           trk_wr_q, trk_wr_d;
  logic           intrq_q, intrq_d;
  logic           index_prev_q;
  logic [7:0]     head_q [DRIVES];
  logic [7:0]     head_d [DRIVES];
`ifdef WD279X_HEAD_UNLOAD_EN
  logic [3:0]     unload_q, unload_d;
`endif

  logic [7:0] cur_head;
  logic [7:0] new_head;
  logic       set_head;
  logic [7:0] rate_ld;
  logic       idx_fall;
  logic       seekish;
  logic       is_restore;
  logic       id_match;

  // RESTORE and SEEK share the compare loop and always update the track
  // register; the STEP family only does so when u is set.
  assign seekish    = (cmd_q[6:5] == 2'b00);
  assign is_restore = (cmd_q[6:4] == 3'b000);
  assign idx_fall   = index_prev_q & ~INDEXn;
  assign id_match   = id_valid && (id_track == reg_track_in);

  always_comb begin
    cur_head = '0;
    for (int unsigned i = 0; i < DRIVES; i++) begin
      if (drv_q == DSW'(i)) cur_head = head_q[i];
    end
  end

  always_comb begin
    case (cmd_q[1:0])
      2'd0:    rate_ld = 8'd6;
      2'd1:    rate_ld = 8'd12;
      2'd2:    rate_ld = 8'd20;
      default: rate_ld = 8'd30;
    endcase
    if (TEST != 0) rate_ld = 8'd2;
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    drv_d      = drv_q;
    target_d   = target_q;
    step_cnt_d = step_cnt_q;
    wait_d     = wait_q;
    idx_cnt_d  = idx_cnt_q;
    stepn_d    = stepn_q;
    sdirn_d    = sdirn_q;
    hld_d      = hld_q;
    seek_err_d = seek_err_q;
    crc_err_d  = crc_err_q;
    trk_out_d  = trk_out_q;
    trk_wr_d   = 1'b0;
    intrq_d    = 1'b0;
    set_head   = 1'b0;
    new_head   = cur_head;
`ifdef WD279X_HEAD_UNLOAD_EN
    unload_d   = unload_q;
`endif

    if (interrupt) begin
      // Abort: everything else (errors, heads, track register) is held and
      // the strobes above stay low, so no pending write or INTRQ escapes.
      state_d = S_IDLE;
      stepn_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (command_start && !command[7]) begin
            cmd_d      = command[6:0];
            drv_d      = drive_sel;
            seek_err_d = 1'b0;
            crc_err_d  = 1'b0;
            hld_d      = command[3];
            step_cnt_d = '0;
`ifdef WD279X_HEAD_UNLOAD_EN
            unload_d   = '0;
`endif
            case (command[6:4])
              3'b000: begin
                target_d = '0;
                sdirn_d  = 1'b0;
                state_d  = S_COMPARE;
              end
              3'b001: begin
                target_d = reg_data;
                state_d  = S_COMPARE;
              end
              3'b010, 3'b011: state_d = S_PULSE;
              3'b100, 3'b101: begin
                sdirn_d = 1'b1;
                state_d = S_PULSE;
              end
              default: begin
                sdirn_d = 1'b0;
                state_d = S_PULSE;
              end
            endcase
          end
`ifdef WD279X_HEAD_UNLOAD_EN
          else if (hld_q && idx_fall) begin
            if (unload_q == 4'd14) begin
              hld_d    = 1'b0;
              unload_d = '0;
            end else begin
              unload_d = unload_q + 4'd1;
            end
          end
`endif
        end

        S_COMPARE: begin
          if (reg_track_in == target_q) begin
            state_d = S_VERIFY;
          end else begin
            sdirn_d = (target_q > reg_track_in);
            state_d = S_PULSE;
          end
        end

        S_PULSE: begin
          if (!sdirn_q && !TRK00n) begin
            trk_out_d = '0;
            trk_wr_d  = 1'b1;
            set_head  = 1'b1;
            new_head  = '0;
            state_d   = S_VERIFY;
          end else if (is_restore && step_cnt_q == 8'hFF) begin
            seek_err_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            stepn_d  = 1'b0;
            set_head = 1'b1;
            if (sdirn_q) begin
              if (cur_head < MAX_C) new_head = cur_head + 8'd1;
            end else begin
              if (cur_head != 8'd0) new_head = cur_head - 8'd1;
            end
            if (seekish || cmd_q[4]) begin
              trk_out_d = sdirn_q ? reg_track_in + 8'd1 : reg_track_in - 8'd1;
              trk_wr_d  = 1'b1;
            end
            step_cnt_d = step_cnt_q + 8'd1;
            wait_d     = rate_ld;
            state_d    = S_WAIT;
          end
        end

        S_WAIT: begin
          if (msclk) begin
            stepn_d = 1'b1;
            if (wait_q <= 8'd1) state_d = seekish ? S_COMPARE : S_VERIFY;
            else                wait_d  = wait_q - 8'd1;
          end
        end

        S_VERIFY: begin
          if (!cmd_q[2]) begin
            state_d = S_DONE;
          end else begin
            hld_d   = 1'b1;
            wait_d  = SETTLE_LD;
            state_d = S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (msclk) begin
            if (wait_q <= 8'd1) begin
              idx_cnt_d = '0;
              state_d   = S_SCAN;
            end else begin
              wait_d = wait_q - 8'd1;
            end
          end
        end

        S_SCAN: begin
          // A good-CRC match beats an index limit in the same cycle; a
          // bad-CRC match only flags CRC_ERR and lets index counting proceed.
          if (id_match && id_crc_ok) begin
            crc_err_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            if (id_match) crc_err_d = 1'b1;
            if (idx_fall) begin
              if ((idx_cnt_q + 8'd1) >= IDX_LIM) begin
                seek_err_d = 1'b1;
                state_d    = S_DONE;
              end else begin
                idx_cnt_d = idx_cnt_q + 8'd1;
              end
            end
          end
        end

        S_DONE: begin
          intrq_d = 1'b1;
          state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end

    for (int unsigned i = 0; i < DRIVES; i++) begin
      head_d[i] = head_q[i];
      if (set_head && drv_q == DSW'(i)) head_d[i] = new_head;
    end
  end

  always_ff @(posedge clk) begin
    index_prev_q <= INDEXn;
    if (!MRn) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      drv_q      <= '0;
      target_q   <= '0;
      step_cnt_q <= '0;
      wait_q     <= '0;
      idx_cnt_q  <= '0;
      stepn_q    <= 1'b1;
      sdirn_q    <= 1'b1;
      hld_q      <= 1'b0;
      seek_err_q <= 1'b0;
      crc_err_q  <= 1'b0;
      trk_out_q  <= '0;
      trk_wr_q   <= 1'b0;
      intrq_q    <= 1'b0;
      for (int unsigned i = 0; i < DRIVES; i++) head_q[i] <= '0;
`ifdef WD279X_HEAD_UNLOAD_EN
      unload_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      drv_q      <= drv_d;
      target_q   <= target_d;
      step_cnt_q <= step_cnt_d;
      wait_q     <= wait_d;
      idx_cnt_q  <= idx_cnt_d;
      stepn_q    <= stepn_d;
      sdirn_q    <= sdirn_d;
      hld_q      <= hld_d;
      seek_err_q <= seek_err_d;
      crc_err_q  <= crc_err_d;
      trk_out_q  <= trk_out_d;
      trk_wr_q   <= trk_wr_d;
      intrq_q    <= intrq_d;
      for (int unsigned i = 0; i < DRIVES; i++) head_q[i] <= head_d[i];
`ifdef WD279X_HEAD_UNLOAD_EN
      unload_q   <= unload_d;
`endif
    end
  end

  assign reg_track_out   = trk_out_q;
  assign reg_track_write = trk_wr_q;
  assign STEPn           = stepn_q;
  assign SDIRn           = sdirn_q;
  assign HLD             = hld_q;
  assign INTRQ           = intrq_q;
  assign head_cyl        = cur_head;
  assign status          = {2'b00, hld_q, seek_err_q, crc_err_q, ~TRK00n, ~INDEXn,
                            (state_q != S_IDLE)};

endmodule

// File: tb/tb_wd279x_type1_multi.sv
module tb_wd279x_type1_multi;

  logic       clk = 1'b0;
  logic       MRn, msclk, interrupt, command_start;
  logic [7:0] command, reg_data, reg_track_in, id_track;
  logic [0:0] drive_sel;
  logic       id_valid, id_crc_ok, INDEXn, TRK00n;
  logic [7:0] reg_track_out, head_cyl, status;
  logic       reg_track_write, STEPn, SDIRn, HLD, INTRQ;

  wd279x_type1_multi #(.DRIVES(2), .MAX_CYL(81), .INDEX_LIMIT(5),
                       .SETTLE_MS(15), .TEST(0)) dut (
    .clk(clk), .MRn(MRn), .msclk(msclk), .interrupt(interrupt),
    .command_start(command_start), .command(command), .reg_data(reg_data),
    .drive_sel(drive_sel), .reg_track_in(reg_track_in),
    .reg_track_out(reg_track_out), .reg_track_write(reg_track_write),
    .id_valid(id_valid), .id_track(id_track), .id_crc_ok(id_crc_ok),
    .INDEXn(INDEXn), .TRK00n(TRK00n), .STEPn(STEPn), .SDIRn(SDIRn),
    .HLD(HLD), .head_cyl(head_cyl), .status(status), .INTRQ(INTRQ)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0, n_bad = 0;
  int          n_steps = 0, n_wr = 0, n_intrq = 0;
  logic        stepn_prev = 1'b1;
  logic [23:0] wr_hist = '0;
  logic        follow = 1'b1;
  logic        ms_en = 1'b1;
  int          ms_div = 0;
  int          s0, w0, i0, g;

  // One clock: sample #1 after the edge, model the track register and the
  // msclk divider (one-cycle msclk pulse every 4 clocks).
  task automatic cyc();
    @(posedge clk); #1;
    if (stepn_prev && !STEPn) n_steps++;
    stepn_prev = STEPn;
    if (reg_track_write) begin
      n_wr++;
      wr_hist = {wr_hist[15:0], reg_track_out};
      if (follow) reg_track_in = reg_track_out;
    end
    if (INTRQ) n_intrq++;
    ms_div = (ms_div + 1) % 4;
    msclk = ms_en && (ms_div == 0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_cmd(input logic [7:0] c);
    command = c;
    command_start = 1'b1;
    cyc();
    command_start = 1'b0;
  endtask

  task automatic wait_intrq(input int budget);
    int b, k;
    b = n_intrq;
    k = 0;
    while (n_intrq == b && k < budget) begin
      cyc();
      k++;
    end
  endtask

  task automatic snap();
    s0 = n_steps; w0 = n_wr; i0 = n_intrq;
  endtask

  initial begin
    MRn = 1'b0; msclk = 1'b0; interrupt = 1'b0; command_start = 1'b0;
    command = '0; reg_data = '0; reg_track_in = '0; id_track = '0;
    drive_sel = '0; id_valid = 1'b0; id_crc_ok = 1'b0;
    INDEXn = 1'b1; TRK00n = 1'b1;
    repeat (3) cyc();
    chk("rst_STEPn", STEPn, 1);
    chk("rst_SDIRn", SDIRn, 1);
    chk("rst_HLD", HLD, 0);
    chk("rst_INTRQ", INTRQ, 0);
    chk("rst_wr", reg_track_write, 0);
    chk("rst_trkout", reg_track_out, 0);
    chk("rst_head", head_cyl, 0);
    chk("rst_status", status, 8'h00);
    MRn = 1'b1;
    cyc();

    // RESTORE, TRK00 asserted after the third step pulse
    reg_track_in = 8'd10;
    snap();
    start_cmd(8'h00);
    chk("restore_busy", status[0], 1);
    g = 0;
    while (n_intrq == i0 && g < 2000) begin
      cyc();
      if (n_steps - s0 >= 3) TRK00n = 1'b0;
      g++;
    end
    chk("restore_steps", n_steps - s0, 3);
    chk("restore_writes", n_wr - w0, 4);
    chk("restore_intrq", n_intrq - i0, 1);
    chk("restore_trkout", reg_track_out, 0);
    chk("restore_SDIRn", SDIRn, 0);
    chk("restore_status", status, 8'h04);
    cyc();
    chk("restore_intrq_1cyc", INTRQ, 0);

    // SEEK 0x14 from track 2 to 5 with verify
    TRK00n = 1'b1;
    reg_track_in = 8'd2;
    reg_data = 8'd5;
    snap();
    start_cmd(8'h14);
    g = 0;
    while (!HLD && g < 500) begin cyc(); g++; end
    chk("seek_hld_up", HLD, 1);
    repeat (30) cyc();
    id_track = 8'd5; id_crc_ok = 1'b1; id_valid = 1'b1;
    cyc();
    id_valid = 1'b0;
    repeat (3) cyc();
    chk("seek_settle_ignores_id", {status[0], 8'(n_intrq - i0)}, {1'b1, 8'd0});
    repeat (60) cyc();
    id_valid = 1'b1;
    cyc();
    id_valid = 1'b0;
    wait_intrq(10);
    chk("seek_intrq", n_intrq - i0, 1);
    chk("seek_steps", n_steps - s0, 3);
    chk("seek_wr_seq", wr_hist, 24'h030405);
    chk("seek_head", head_cyl, 3);
    chk("seek_status", status, 8'h20);

    // STEP-IN u=0, then u=1, STEP-OUT u=1, STEP u=1
    snap();
    start_cmd(8'h40);
    wait_intrq(200);
    chk("stepin_u0", {8'(n_steps - s0), 8'(n_wr - w0), 8'(n_intrq - i0), head_cyl},
        {8'd1, 8'd0, 8'd1, 8'd4});
    chk("stepin_u0_hld", HLD, 0);
    snap();
    start_cmd(8'h50);
    wait_intrq(200);
    chk("stepin_u1", {8'(n_wr - w0), head_cyl, reg_track_out, 7'd0, SDIRn},
        {8'd1, 8'd5, 8'd6, 8'd1});
    snap();
    start_cmd(8'h70);
    wait_intrq(200);
    chk("stepout_u1", {8'(n_wr - w0), head_cyl, reg_track_out, 7'd0, SDIRn},
        {8'd1, 8'd4, 8'd5, 8'd0});
    snap();
    start_cmd(8'h30);
    wait_intrq(200);
    chk("step_u1", {8'(n_wr - w0), head_cyl, reg_track_out, 7'd0, SDIRn},
        {8'd1, 8'd3, 8'd4, 8'd0});

    // Drive 1 has its own counter; drive_sel changes while busy are ignored
    drive_sel = 1'b1;
    snap();
    start_cmd(8'h58);
    drive_sel = 1'b0;
    wait_intrq(200);
    chk("drv1_head", head_cyl, 1);
    chk("drv1_trkout_hld", {reg_track_out, 7'd0, HLD}, {8'd5, 8'd1});

    // RESTORE with TRK00n stuck high: 255-step limit
    follow = 1'b0;
    reg_track_in = 8'h10;
    snap();
    start_cmd(8'h00);
    wait_intrq(12000);
    chk("r255_intrq", n_intrq - i0, 1);
    chk("r255_steps", n_steps - s0, 255);
    chk("r255_writes", n_wr - w0, 255);
    chk("r255_trkout", reg_track_out, 8'h0F);
    chk("r255_head", head_cyl, 0);
    chk("r255_status", status, 8'h10);

    // SEEK verify: bad-CRC match, then index limit
    follow = 1'b1;
    reg_track_in = 8'd4;
    reg_data = 8'd4;
    snap();
    start_cmd(8'h14);
    g = 0;
    while (!HLD && g < 100) begin cyc(); g++; end
    repeat (90) cyc();
    id_track = 8'd4; id_crc_ok = 1'b0; id_valid = 1'b1;
    cyc();
    id_valid = 1'b0;
    cyc();
    chk("crc_bad_status", status, 8'h29);
    id_track = 8'd7; id_crc_ok = 1'b1; id_valid = 1'b1;
    cyc();
    id_valid = 1'b0;
    cyc();
    chk("wrong_track_ignored", status, 8'h29);
    for (int k = 0; k < 4; k++) begin
      INDEXn = 1'b0; cyc();
      INDEXn = 1'b1; cyc(); cyc(); cyc();
    end
    chk("idx4_still_busy", {status, 8'(n_intrq - i0)}, {8'h29, 8'd0});
    INDEXn = 1'b0; cyc();
    INDEXn = 1'b1;
    wait_intrq(10);
    chk("idx5_intrq", n_intrq - i0, 1);
    chk("idx5_status", status, 8'h38);
    chk("idx5_steps", n_steps - s0, 0);

    // interrupt during WAIT
    ms_en = 1'b0;
    snap();
    start_cmd(8'h43);
    cyc();
    chk("int_stepn_low", STEPn, 0);
    interrupt = 1'b1;
    cyc();
    chk("int_stepn_high", STEPn, 1);
    chk("int_status", status, 8'h00);
    interrupt = 1'b0;
    ms_en = 1'b1;
    repeat (150) cyc();
    chk("int_no_intrq", n_intrq - i0, 0);
    chk("int_head", head_cyl, 1);

    // MRn mid-SEEK on drive 1
    ms_en = 1'b0;
    drive_sel = 1'b1;
    reg_track_in = 8'd10;
    reg_data = 8'd30;
    start_cmd(8'h1B);
    cyc();
    cyc();
    chk("mr_pre", {STEPn, HLD, reg_track_write, head_cyl}, {1'b0, 1'b1, 1'b1, 8'd2});
    MRn = 1'b0;
    cyc();
    chk("mr_ctrl", {STEPn, SDIRn, HLD, INTRQ, reg_track_write}, 5'b11000);
    chk("mr_trkout", reg_track_out, 0);
    chk("mr_head", head_cyl, 0);
    chk("mr_status", status, 8'h00);
    MRn = 1'b1;
    ms_en = 1'b1;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
